// File: rtl/core_seq_pkg.sv
// Shared types and inst-word bit positions for the NPU instruction sequencer.
// Combinational definitions only; no latency or flow control.
package core_seq_pkg;

    localparam int INST_W = 20;
    localparam int CNT_W  = 16;

    localparam int INST_SFP_WR2PMEM = 19;
    localparam int INST_SFP_DIV     = 18;
    localparam int INST_SFP_ACC     = 17;
    localparam int INST_OFIFO_RD    = 16;
    localparam int INST_QK_LSB      = 12;
    localparam int INST_PM_LSB      = 8;
    localparam int INST_EXECUTE     = 7;
    localparam int INST_LOAD        = 6;
    localparam int INST_QMEM_RD     = 5;
    localparam int INST_QMEM_WR     = 4;
    localparam int INST_KMEM_RD     = 3;
    localparam int INST_KMEM_WR     = 2;
    localparam int INST_PMEM_RD     = 1;
    localparam int INST_PMEM_WR     = 0;

    typedef enum logic [4:0] {
        S_IDLE,
        S_K_LOAD,
        S_K_END,
        S_K_OFF,
        S_GAP1,
        S_EXEC,
        S_EXEC_END,
        S_GAP2,
        S_DRAIN,
        S_DRAIN_END,
        S_ACC_SET,
        S_ACC_RUN,
        S_ACC_END,
        S_DIV_PRE,
        S_DIV_SLOT,
        S_DIV_END,
        S_DONE
    } state_t;

endpackage

// File: rtl/seq_cnt.sv
// Loadable down-counter with terminal flag; load takes effect next cycle.
// No flow control: counts whenever enabled, holds at zero.
module seq_cnt
    import core_seq_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign last = (cnt == '0);

endmodule

// File: rtl/core_inst_seq.sv
// Autonomous inst-word sequencer for the NPU core; first word 1 cycle after start.
// No backpressure: core consumes inst every cycle; start ignored while busy.
module core_inst_seq
    import core_seq_pkg::*;
#(
    parameter int col    = 8,
    parameter int addr_w = 4,
    parameter int gap    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [addr_w:0]   nq,
    input  logic              mode_norm,
    input  logic              abort,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done
);

    localparam logic [addr_w:0] NQ_LIM   = {1'b1, {addr_w{1'b0}}};
    localparam logic [addr_w:0] NQ_LIM_N = {1'b0, {addr_w{1'b1}}};

    logic [1:0]       rst_sync;
    logic             rst_n;
    state_t           state, nxt;
    logic [CNT_W-1:0] idx, cnt, cnt_val;
    logic             cnt_last, cnt_load, cnt_en, accept, kill;
    logic [addr_w:0]  nq_r, nq_sat, nq_lim;
    logic             norm_r;

    // Assertion is immediate; release is delayed two edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_n = rst_sync[1];

    function automatic logic [CNT_W-1:0] len_m1(input state_t s, input logic [CNT_W-1:0] n);
        case (s)
            S_K_LOAD:         return CNT_W'(col);
            S_GAP1, S_GAP2:   return CNT_W'(gap - 1);
            S_EXEC, S_DRAIN:  return n - 1'b1;
            S_ACC_RUN:        return (n << 1) - 1'b1;
            S_DIV_PRE:        return CNT_W'(3);
            S_DIV_SLOT:       return (n << 2) + CNT_W'(3);
            default:          return '0;
        endcase
    endfunction

    function automatic logic [INST_W-1:0] enc(input state_t s, input logic [CNT_W-1:0] c);
        logic [INST_W-1:0]  w;
        logic [CNT_W-1:0]   k;
        w = '0;
        k = c >> 2;
        case (s)
            S_K_LOAD: begin
                w[INST_LOAD]    = 1'b1;
                w[INST_KMEM_RD] = (c != '0);
                if (c >= CNT_W'(2)) w[INST_QK_LSB +: addr_w] = addr_w'(c - 1'b1);
            end
            S_K_END: w[INST_LOAD] = 1'b1;
            S_EXEC: begin
                w[INST_EXECUTE]          = 1'b1;
                w[INST_QMEM_RD]          = 1'b1;
                w[INST_QK_LSB +: addr_w] = addr_w'(c);
            end
            S_DRAIN: begin
                w[INST_OFIFO_RD]         = 1'b1;
                w[INST_PMEM_WR]          = 1'b1;
                w[INST_PM_LSB +: addr_w] = addr_w'(c);
            end
            S_ACC_SET, S_ACC_RUN: begin
                w[INST_PMEM_RD] = 1'b1;
                w[INST_SFP_ACC] = 1'b1;
                if (s == S_ACC_RUN) w[INST_PM_LSB +: addr_w] = addr_w'(c >> 1);
            end
            S_DIV_PRE: begin
                if (c == '0) w[INST_SFP_DIV] = 1'b1;
                else         w[INST_PMEM_RD] = 1'b1;
            end
            S_DIV_SLOT: begin
                // s0 writes back slot k, the rest prefetch address k+1.
                w[INST_PMEM_RD]     = 1'b1;
                w[INST_SFP_WR2PMEM] = 1'b1;
                case (c[1:0])
                    2'd0: begin
                        w[INST_SFP_DIV]          = 1'b1;
                        w[INST_PMEM_WR]          = 1'b1;
                        w[INST_PM_LSB +: addr_w] = addr_w'(k);
                    end
                    2'd1: begin
                        w[INST_SFP_DIV]          = 1'b1;
                        w[INST_PM_LSB +: addr_w] = addr_w'(k + 1'b1);
                    end
                    default: w[INST_PM_LSB +: addr_w] = addr_w'(k + 1'b1);
                endcase
            end
            default: w = '0;
        endcase
        return w;
    endfunction

    always_comb begin
        nq_lim = mode_norm ? NQ_LIM_N : NQ_LIM;
        nq_sat = (nq > nq_lim) ? nq_lim : nq;
        accept = (state == S_IDLE) && start && !busy && !abort;
        kill   = abort && (state != S_IDLE);
        nxt    = state;
        if (state == S_IDLE) begin
            if (accept) nxt = (nq_sat == '0) ? S_DONE : S_K_LOAD;
        end else if (cnt_last) begin
            case (state)
                S_K_LOAD:    nxt = S_K_END;
                S_K_END:     nxt = S_K_OFF;
                S_K_OFF:     nxt = (gap > 0) ? S_GAP1 : S_EXEC;
                S_GAP1:      nxt = S_EXEC;
                S_EXEC:      nxt = S_EXEC_END;
                S_EXEC_END:  nxt = (gap > 0) ? S_GAP2 : S_DRAIN;
                S_GAP2:      nxt = S_DRAIN;
                S_DRAIN:     nxt = S_DRAIN_END;
                S_DRAIN_END: nxt = norm_r ? S_ACC_SET : S_DONE;
                S_ACC_SET:   nxt = S_ACC_RUN;
                S_ACC_RUN:   nxt = S_ACC_END;
                S_ACC_END:   nxt = S_DIV_PRE;
                S_DIV_PRE:   nxt = S_DIV_SLOT;
                S_DIV_SLOT:  nxt = S_DIV_END;
                S_DIV_END:   nxt = S_DONE;
                default:     nxt = S_IDLE;
            endcase
        end
        if (kill) nxt = S_IDLE;
        cnt_load = (nxt != state);
        cnt_en   = (state != S_IDLE);
        cnt_val  = len_m1(nxt, CNT_W'(nq_r));
    end

    seq_cnt #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (cnt_en),
        .cnt      (cnt),
        .last     (cnt_last)
    );

    // Outputs are the registered encoding of the previous cycle's state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            idx    <= '0;
            nq_r   <= '0;
            norm_r <= 1'b0;
            inst   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state <= nxt;
            idx   <= (nxt != state || state == S_IDLE) ? '0 : idx + 1'b1;
            if (accept) begin
                nq_r   <= nq_sat;
                norm_r <= mode_norm;
            end
            if (kill) begin
                inst <= '0;
                busy <= 1'b0;
                done <= 1'b0;
            end else begin
                inst <= enc(state, idx);
                busy <= (state != S_IDLE);
                done <= (state == S_DONE);
            end
        end
    end

endmodule

// File: tb/tb_core_inst_seq.sv
// Directed bench for core_inst_seq: cycle-indexed traces checked against hand-derived words.
module tb_core_inst_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  nq = 5'd0;
    logic        mode_norm = 1'b0;
    logic        abort = 1'b0;
    logic [19:0] inst;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    logic [19:0] tr_inst [0:199];
    logic        tr_done [0:199];
    logic        tr_busy [0:199];

    core_inst_seq #(.col(8), .addr_w(4), .gap(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .nq        (nq),
        .mode_norm (mode_norm),
        .abort     (abort),
        .inst      (inst),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start is sampled on edge 0; trace index c is the value seen after edge c.
    task automatic run(input logic [4:0] q, input logic norm, input int ncyc,
                       input int pulse_cyc, input int abort_cyc);
        for (int i = 0; i < 200; i++) begin
            tr_inst[i] = '0;
            tr_done[i] = 1'b0;
            tr_busy[i] = 1'b0;
        end
        nq = q;
        mode_norm = norm;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            start = (pulse_cyc == c - 1);
            abort = (abort_cyc == c - 1);
            tick();
            start = 1'b0;
            abort = 1'b0;
            tr_inst[c] = inst;
            tr_done[c] = done;
            tr_busy[c] = busy;
        end
    endtask

    function automatic int first_done(input int ncyc);
        for (int c = 1; c <= ncyc; c++) if (tr_done[c]) return c;
        return -1;
    endfunction

    function automatic int count_bit(input int b, input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (tr_inst[c][b]) n++;
        return n;
    endfunction

    initial begin
        int n;

        // Reset held: start must do nothing.
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("rst_inst", 32'(inst), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        reset = 1'b1;
        repeat (4) tick();
        chk("idle_inst", 32'(inst), 32'h0);

        // Default pass, with a start pulse landing on the done cycle.
        run(5'd8, 1'b0, 60, 50, -1);
        chk("kl_c1", 32'(tr_inst[1]), 32'h00040);
        chk("kl_c2", 32'(tr_inst[2]), 32'h00048);
        chk("kl_c3", 32'(tr_inst[3]), 32'h01048);
        chk("kl_c9", 32'(tr_inst[9]), 32'h07048);
        chk("k_end", 32'(tr_inst[10]), 32'h00040);
        chk("k_off", 32'(tr_inst[11]), 32'h0);
        for (int c = 12; c <= 21; c++) chk($sformatf("gap1_%0d", c), 32'(tr_inst[c]), 32'h0);
        for (int i = 0; i < 8; i++)
            chk($sformatf("exec_%0d", i), 32'(tr_inst[22 + i]), 32'h000A0 | (32'(i) << 12));
        chk("exec_end", 32'(tr_inst[30]), 32'h0);
        for (int c = 31; c <= 40; c++) chk($sformatf("gap2_%0d", c), 32'(tr_inst[c]), 32'h0);
        for (int i = 0; i < 8; i++)
            chk($sformatf("drain_%0d", i), 32'(tr_inst[41 + i]), 32'h10001 | (32'(i) << 8));
        chk("drain_end", 32'(tr_inst[49]), 32'h0);
        chk("done_cyc", 32'(first_done(60)), 32'd50);
        n = 0;
        for (int c = 1; c <= 60; c++) n += int'(tr_done[c]);
        chk("done_cnt", 32'(n), 32'd1);
        chk("busy_c1", 32'(tr_busy[1]), 32'h1);
        chk("busy_c50", 32'(tr_busy[50]), 32'h1);
        chk("busy_c51", 32'(tr_busy[51]), 32'h0);
        chk("busy_c60", 32'(tr_busy[60]), 32'h0);
        chk("inst_c55", 32'(tr_inst[55]), 32'h0);
        chk("no_qmem_wr", 32'(count_bit(4, 1, 60)), 32'd0);
        chk("no_kmem_wr", 32'(count_bit(2, 1, 60)), 32'd0);

        // Norm pass.
        run(5'd8, 1'b1, 115, -1, -1);
        chk("n_exec0", 32'(tr_inst[22]), 32'h000A0);
        chk("acc_set", 32'(tr_inst[50]), 32'h20002);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("acc_a%0d", k), 32'(tr_inst[51 + 2 * k][11:8]), 32'(k));
            chk($sformatf("acc_b%0d", k), 32'(tr_inst[52 + 2 * k][11:8]), 32'(k));
        end
        chk("acc_end", 32'(tr_inst[67]), 32'h0);
        chk("div_pre0", 32'(tr_inst[68]), 32'h40000);
        chk("div_pre1", 32'(tr_inst[69]), 32'h00002);
        chk("div_pre3", 32'(tr_inst[71]), 32'h00002);
        chk("div_k0_s0", 32'(tr_inst[72]), 32'hC0003);
        chk("div_k0_s1", 32'(tr_inst[73]), 32'hC0102);
        chk("div_k0_s2", 32'(tr_inst[74]), 32'h80102);
        chk("div_k8_s0", 32'(tr_inst[104]), 32'hC0803);
        chk("div_k8_s1", 32'(tr_inst[105]), 32'hC0902);
        chk("div_k8_s3", 32'(tr_inst[107]), 32'h80902);
        chk("div_end", 32'(tr_inst[108]), 32'h0);
        chk("div_wr_cnt", 32'(count_bit(0, 68, 108)), 32'd9);
        chk("n_done_cyc", 32'(first_done(115)), 32'd109);
        chk("n_busy_110", 32'(tr_busy[110]), 32'h0);

        // nq=0: immediate done, never any instruction.
        run(5'd0, 1'b0, 10, -1, -1);
        n = 0;
        for (int c = 1; c <= 10; c++) if (tr_inst[c] != '0) n++;
        chk("z_inst", 32'(n), 32'd0);
        chk("z_done1", 32'(tr_done[1]), 32'h1);
        chk("z_done2", 32'(tr_done[2]), 32'h0);
        chk("z_busy1", 32'(tr_busy[1]), 32'h1);
        chk("z_busy2", 32'(tr_busy[2]), 32'h0);

        // Saturation.
        run(5'd31, 1'b1, 170, -1, -1);
        chk("sat_n_exec", 32'(count_bit(7, 1, 170)), 32'd15);
        chk("sat_n_done", 32'(first_done(170)), 32'd165);
        run(5'd20, 1'b0, 70, -1, -1);
        chk("sat_exec", 32'(count_bit(7, 1, 70)), 32'd16);
        chk("sat_drain", 32'(count_bit(16, 1, 70)), 32'd16);
        chk("sat_done", 32'(first_done(70)), 32'd66);

        // Abort during EXEC.
        run(5'd8, 1'b0, 60, -1, 25);
        chk("ab_c25", 32'(tr_inst[25]), 32'h030A0);
        n = 0;
        for (int c = 26; c <= 60; c++) if (tr_inst[c] != '0 || tr_busy[c]) n++;
        chk("ab_quiet", 32'(n), 32'd0);
        chk("ab_no_done", 32'(first_done(60)), 32'hFFFFFFFF);
        run(5'd8, 1'b0, 55, -1, -1);
        chk("ab_rerun_done", 32'(first_done(55)), 32'd50);
        chk("ab_rerun_ex", 32'(tr_inst[29]), 32'h070A0);

        // Start repulsed mid-pass, then async reset in DRAIN.
        run(5'd8, 1'b0, 44, 30, -1);
        chk("rp_gap", 32'(tr_inst[35]), 32'h0);
        chk("rp_busy", 32'(tr_busy[35]), 32'h1);
        chk("rp_drain", 32'(tr_inst[44]), 32'h10301);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_inst", 32'(inst), 32'h0);
        chk("ar_busy", 32'(busy), 32'h0);
        chk("ar_done", 32'(done), 32'h0);
        tick();
        chk("ar_hold", 32'(inst), 32'h0);
        reset = 1'b1;
        repeat (4) tick();
        run(5'd8, 1'b0, 55, -1, -1);
        chk("post_rst_done", 32'(first_done(55)), 32'd50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_inst_seq.md
# core_inst_seq

Autonomous instruction sequencer for the single-core NPU. It replaces hand-stepped instruction driving with a parametrised FSM that emits the 20-bit `inst` word consumed by `core`. The full attention pass runs K load, Q execute, ofifo-to-pmem drain, and an optional norm (SFP accumulate + divide). Vector count, column count and idle-gap length are set by parameter or at run time. It sits between the host/test harness and `core.inst`.

## Interface
- `col`, 8: dot-product units (K vectors loaded per pass)
- `addr_w`, 4: width of qkmem_add / pmem_add fields
- `gap`, 10: idle cycles inserted after K load and after execute
- `clk` input 1: rising-edge clock
- `reset` input 1: reset is asynchronous and active-low; `reset`=0 clears all state
- `start` input 1: one-cycle pulse that launches a pass; ignored while `busy`=1
- `nq` input addr_w+1: Q vectors for this pass, sampled on `start`
- `mode_norm` input 1: sampled on `start`; 1 appends the ACC and DIV phases
- `abort` input 1: synchronous; forces a return to IDLE
- `inst` output 20: registered instruction word to `core`
- `busy` output 1: high from the cycle after `start` through the `done` cycle
- `done` output 1: one-cycle completion pulse

## Operation
- `inst` bit map: [19] sfp_wr2pmem, [18] sfp_div, [17] sfp_acc, [16] ofifo_rd, [15:12] qkmem_add, [11:8] pmem_add, [7] execute, [6] load, [5] qmem_rd, [4] qmem_wr, [3] kmem_rd, [2] kmem_wr, [1] pmem_rd, [0] pmem_wr.
- Write bits (qmem_wr, kmem_wr) are never asserted; memory fill stays with the host.
- Any field not listed for a state is 0. Cycle index c counts from 0 within each state.
- `nq` range and saturation:
  - legal 1..2^addr_w, or 1..2^addr_w−1 when `mode_norm`=1 (DIV addresses up to nq);
  - larger values saturate to the maximum;
  - `nq`=0 skips every phase and gives `done` the cycle after `start`.
- States and `inst` contents:
  - IDLE: `inst`=0.
  - K_LOAD, col+1 cycles: load=1; kmem_rd=1 for c≥1; qkmem_add = c−1 for c≥2, else 0.
  - K_END, 1 cycle: load=1 only.
  - K_OFF, 1 cycle: all zero.
  - GAP1, `gap` cycles: all zero.
  - EXEC, nq cycles: execute=1, qmem_rd=1, qkmem_add=c.
  - EXEC_END, 1 cycle: zero.
  - GAP2, `gap` cycles: zero.
  - DRAIN, nq cycles: ofifo_rd=1, pmem_wr=1, pmem_add=c.
  - DRAIN_END, 1 cycle: zero.
  - ACC (norm only): 1 setup cycle with pmem_rd=1, sfp_acc=1, add 0; then 2 cycles per k=0..nq−1 with pmem_add=k; then 1 zero cycle.
  - DIV (norm only), in order:
    - 1 cycle sfp_div=1;
    - 1 cycle pmem_rd=1;
    - 2 cycles pmem_rd=1;
    - nq+1 slots for k=0..nq, 4 cycles each, with pmem_rd=1 and sfp_wr2pmem=1 throughout:
      - s0: sfp_div=1, pmem_wr=1, pmem_add=k;
      - s1: sfp_div=1, pmem_add=k+1;
      - s2, s3: pmem_add=k+1;
    - 1 zero cycle.
  - DONE, 1 cycle: `done`=1, `inst`=0, then IDLE.
- `abort` in any non-IDLE state:
  - `inst`=0 and state IDLE from the next cycle;
  - no `done` pulse; `busy` falls the same edge.

## Timing
- Reset values: `inst`=0, `busy`=0, `done`=0, state IDLE, all counters 0.
- Async `reset` assertion mid-pass zeroes outputs immediately. Deassertion is synchronised internally.
- Start on edge 0 puts the first K_LOAD word on `inst` after edge 1, so latency is 1 cycle.
- Non-norm pass: active cycles = col + 2·nq + 2·gap + 5; `done` follows the last active cycle.
- Norm pass adds (2·nq+2) + (4·nq+9) cycles.
- `start` coinciding with `done` is ignored. `start` coinciding with `abort` in IDLE is ignored.

## Structure
- Package `core_seq_pkg` holds:
  - state enum;
  - `inst` bit-index localparams (INST_LOAD=6, etc.);
  - INST_W=20.
- Sub-module `seq_cnt` is a loadable down-counter with terminal flag, reused per phase. The FSM plus field encoding stays in `core_inst_seq`.

## Test plan
- Reset: hold `reset`=0, pulse `start` → `inst`=0, `busy`=0, no `done`.
- Defaults, nq=8, mode_norm=0, start at cycle 0:
  - K_LOAD on cycles 1–9; EXEC on 22–29 with qkmem_add 0..7;
  - DRAIN on 41–48 with pmem_add 0..7;
  - `done` at cycle 50.
- nq=8, mode_norm=1 → `done` at cycle 109. Cover against a golden trace: DIV slot k=8 writes pmem_add 8, and pmem_wr is high exactly 9 cycles within DIV.
- nq=0 → `done` at cycle 1, `inst` never non-zero. nq=31 with mode_norm=1 → saturates to 15 EXEC cycles.
- `abort` at cycle 25 (in EXEC) → `inst`=0 from cycle 26, `busy`=0, no `done`; a fresh `start` then completes normally.
- `start` repulsed while `busy`, and async `reset` asserted mid-DRAIN → pulse ignored; outputs zero within the reset cycle.
